// File: rtl/gfx_pkg.sv
// Shared types and helpers for the span rasterizer.
//   span_state_e  : control FSM states
//   lane_mask_bit : one bit of a beat's lane mask (pixel x+lane lies left of xe)
package gfx_pkg;

    // Width used for all signed coordinate comparisons (covers POINT_WIDTH up to 32
    // plus lane offset headroom).
    localparam int unsigned CMP_W = 34;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_EMIT  = 2'd2,
        ST_DONE  = 2'd3
    } span_state_e;

    // Lane valid when x + lane < xe, evaluated signed.
    function automatic logic lane_mask_bit(input logic signed [CMP_W-1:0] x,
                                           input logic signed [CMP_W-1:0] xe,
                                           input int                      lane);
        return (x + CMP_W'(lane)) < xe;
    endfunction

endpackage

// File: rtl/gfx_clip_setup.sv
// Clip/setup stage: on load_i registers the clipped span bounds and texture start.
//   load_i                   : command accept strobe
//   p0_*/p1_*                : signed destination rectangle (p1 exclusive)
//   clip_en_i, clip_*        : unsigned clip rectangle (x1/y1 exclusive)
//   src_x_i/src_y_i          : texture coordinate matching p0
//   xs_o/ys_o, xe_o/ye_o     : clipped start (inclusive) / end (exclusive, signed)
//   u0_o/v0_o                : texture coordinate at (xs, ys)
//   empty_o                  : clipped rectangle has no pixels
module gfx_clip_setup
    import gfx_pkg::*;
#(
    parameter int unsigned POINT_WIDTH = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          load_i,
    input  logic signed [POINT_WIDTH-1:0] p0_x_i,
    input  logic signed [POINT_WIDTH-1:0] p0_y_i,
    input  logic signed [POINT_WIDTH-1:0] p1_x_i,
    input  logic signed [POINT_WIDTH-1:0] p1_y_i,
    input  logic                          clip_en_i,
    input  logic        [POINT_WIDTH-1:0] clip_x0_i,
    input  logic        [POINT_WIDTH-1:0] clip_y0_i,
    input  logic        [POINT_WIDTH-1:0] clip_x1_i,
    input  logic        [POINT_WIDTH-1:0] clip_y1_i,
    input  logic        [POINT_WIDTH-1:0] src_x_i,
    input  logic        [POINT_WIDTH-1:0] src_y_i,
    output logic        [POINT_WIDTH-1:0] xs_o,
    output logic        [POINT_WIDTH-1:0] ys_o,
    output logic signed [POINT_WIDTH:0]   xe_o,
    output logic signed [POINT_WIDTH:0]   ye_o,
    output logic        [POINT_WIDTH-1:0] u0_o,
    output logic        [POINT_WIDTH-1:0] v0_o,
    output logic                          empty_o
);

    localparam int unsigned EW = POINT_WIDTH + 1;
    // Default far clip edge when clipping is off: largest positive coordinate.
    localparam logic signed [EW-1:0] CLIP_MAX = EW'((64'd1 << (POINT_WIDTH - 1)) - 64'd1);

    logic signed [EW-1:0] p0x_e, p0y_e, p1x_e, p1y_e;
    logic signed [EW-1:0] cx0_e, cy0_e, cx1_e, cy1_e;
    logic signed [EW-1:0] xs_c, xe_c, ys_c, ye_c;
    logic [POINT_WIDTH-1:0] u0_c, v0_c;

    // Intersect with the clip rectangle; destination sign-extended, clip zero-extended.
    always_comb begin
        p0x_e = EW'(p0_x_i);
        p0y_e = EW'(p0_y_i);
        p1x_e = EW'(p1_x_i);
        p1y_e = EW'(p1_y_i);
        cx0_e = clip_en_i ? EW'(clip_x0_i) : '0;
        cy0_e = clip_en_i ? EW'(clip_y0_i) : '0;
        cx1_e = clip_en_i ? EW'(clip_x1_i) : CLIP_MAX;
        cy1_e = clip_en_i ? EW'(clip_y1_i) : CLIP_MAX;
        xs_c  = (p0x_e > cx0_e) ? p0x_e : cx0_e;
        ys_c  = (p0y_e > cy0_e) ? p0y_e : cy0_e;
        xe_c  = (p1x_e < cx1_e) ? p1x_e : cx1_e;
        ye_c  = (p1y_e < cy1_e) ? p1y_e : cy1_e;
        u0_c  = src_x_i + (POINT_WIDTH'(xs_c) - POINT_WIDTH'(p0_x_i));
        v0_c  = src_y_i + (POINT_WIDTH'(ys_c) - POINT_WIDTH'(p0_y_i));
    end

    // Results held for the whole command.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            xs_o    <= '0;
            ys_o    <= '0;
            xe_o    <= '0;
            ye_o    <= '0;
            u0_o    <= '0;
            v0_o    <= '0;
            empty_o <= 1'b1;
        end else if (load_i) begin
            xs_o    <= POINT_WIDTH'(xs_c);
            ys_o    <= POINT_WIDTH'(ys_c);
            xe_o    <= xe_c;
            ye_o    <= ye_c;
            u0_o    <= u0_c;
            v0_o    <= v0_c;
            empty_o <= (xs_c >= xe_c) || (ys_c >= ye_c);
        end
    end

endmodule

// File: rtl/gfx_span_rasterizer.sv
// Rectangle span rasterizer: walks a clipped rectangle row by row, emitting
// LANES pixels per beat with texture coordinates.
//   cmd_valid_i/cmd_ready_o : rectangle command handshake (accepted only in IDLE)
//   p0/p1, clip, src        : command fields, latched on accept
//   abort_i                 : cancels the command in SETUP/EMIT
//   pix_valid_o/pix_ready_i : beat handshake; x_o/y_o/u_o/v_o are lane 0, mask_o per lane
//   done_o                  : one-cycle completion/abort pulse
//   busy_o                  : not IDLE
module gfx_span_rasterizer
    import gfx_pkg::*;
#(
    parameter int unsigned POINT_WIDTH = 16,
    parameter int unsigned LANES       = 4,
    parameter int unsigned TEX_EN      = 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          cmd_valid_i,
    output logic                          cmd_ready_o,
    input  logic signed [POINT_WIDTH-1:0] p0_x_i,
    input  logic signed [POINT_WIDTH-1:0] p0_y_i,
    input  logic signed [POINT_WIDTH-1:0] p1_x_i,
    input  logic signed [POINT_WIDTH-1:0] p1_y_i,
    input  logic                          clip_en_i,
    input  logic        [POINT_WIDTH-1:0] clip_x0_i,
    input  logic        [POINT_WIDTH-1:0] clip_y0_i,
    input  logic        [POINT_WIDTH-1:0] clip_x1_i,
    input  logic        [POINT_WIDTH-1:0] clip_y1_i,
    input  logic        [POINT_WIDTH-1:0] src_x_i,
    input  logic        [POINT_WIDTH-1:0] src_y_i,
    input  logic                          abort_i,
    output logic                          pix_valid_o,
    input  logic                          pix_ready_i,
    output logic        [POINT_WIDTH-1:0] x_o,
    output logic        [POINT_WIDTH-1:0] y_o,
    output logic        [POINT_WIDTH-1:0] u_o,
    output logic        [POINT_WIDTH-1:0] v_o,
    output logic        [LANES-1:0]       mask_o,
    output logic                          done_o,
    output logic                          busy_o
);

    localparam logic signed [CMP_W-1:0] LANES_S = CMP_W'(LANES);
    localparam logic signed [CMP_W-1:0] ONE_S   = CMP_W'(1);

    span_state_e state_q, state_d;
    logic        accept;
    logic [POINT_WIDTH-1:0] xs_s, ys_s, u0_s, v0_s;
    logic signed [POINT_WIDTH:0] xe_s, ye_s;
    logic        empty_s;

    logic [POINT_WIDTH-1:0] x_d, y_d, u_d, v_d;
    logic [LANES-1:0]       mask_d;
    logic signed [CMP_W-1:0] x_ext, y_ext, xd_ext, xe_ext, ye_ext;
    logic        col_last, row_last;

    assign accept = (state_q == ST_IDLE) && cmd_ready_o && cmd_valid_i;

    gfx_clip_setup #(.POINT_WIDTH(POINT_WIDTH)) u_setup (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .load_i    (accept),
        .p0_x_i    (p0_x_i),
        .p0_y_i    (p0_y_i),
        .p1_x_i    (p1_x_i),
        .p1_y_i    (p1_y_i),
        .clip_en_i (clip_en_i),
        .clip_x0_i (clip_x0_i),
        .clip_y0_i (clip_y0_i),
        .clip_x1_i (clip_x1_i),
        .clip_y1_i (clip_y1_i),
        .src_x_i   (src_x_i),
        .src_y_i   (src_y_i),
        .xs_o      (xs_s),
        .ys_o      (ys_s),
        .xe_o      (xe_s),
        .ye_o      (ye_s),
        .u0_o      (u0_s),
        .v0_o      (v0_s),
        .empty_o   (empty_s)
    );

    // Coordinates in EMIT are never negative (clip origin >= 0), so zero-extend x/y.
    always_comb begin
        x_ext    = CMP_W'(x_o);
        y_ext    = CMP_W'(y_o);
        xe_ext   = CMP_W'(xe_s);
        ye_ext   = CMP_W'(ye_s);
        col_last = (x_ext + LANES_S) >= xe_ext;
        row_last = (y_ext + ONE_S) >= ye_ext;
    end

    // Next state and next registered outputs; holding is the default so a stalled beat stays put.
    always_comb begin
        state_d = state_q;
        x_d     = x_o;
        y_d     = y_o;
        u_d     = u_o;
        v_d     = v_o;
        mask_d  = '0;
        xd_ext  = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_SETUP;
            end
            ST_SETUP: begin
                if (abort_i || empty_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_EMIT;
                    x_d     = xs_s;
                    y_d     = ys_s;
                    u_d     = u0_s;
                    v_d     = v0_s;
                end
            end
            ST_EMIT: begin
                if (abort_i) begin
                    state_d = ST_DONE;
                end else if (pix_ready_i) begin
                    if (!col_last) begin
                        x_d = x_o + POINT_WIDTH'(LANES);
                        u_d = u_o + POINT_WIDTH'(LANES);
                    end else begin
                        x_d = xs_s;
                        u_d = u0_s;
                        y_d = y_o + POINT_WIDTH'(1);
                        v_d = v_o + POINT_WIDTH'(1);
                        if (row_last) state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (TEX_EN == 0) begin
            u_d = '0;
            v_d = '0;
        end
        if (state_d == ST_EMIT) begin
            xd_ext = CMP_W'(x_d);
            for (int i = 0; i < int'(LANES); i++) begin
                mask_d[i] = lane_mask_bit(xd_ext, xe_ext, i);
            end
        end
    end

    // State register with all outputs registered from the next state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cmd_ready_o <= 1'b0;
            pix_valid_o <= 1'b0;
            done_o      <= 1'b0;
            busy_o      <= 1'b0;
            mask_o      <= '0;
            x_o         <= '0;
            y_o         <= '0;
            u_o         <= '0;
            v_o         <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_o <= (state_d == ST_IDLE);
            pix_valid_o <= (state_d == ST_EMIT);
            done_o      <= (state_d == ST_DONE);
            busy_o      <= (state_d != ST_IDLE);
            mask_o      <= mask_d;
            x_o         <= x_d;
            y_o         <= y_d;
            u_o         <= u_d;
            v_o         <= v_d;
        end
    end

endmodule

// File: tb/tb_gfx_span_rasterizer.sv
// Self-checking bench for gfx_span_rasterizer (POINT_WIDTH=16, LANES=4, TEX_EN=1).
// Expected beats come from a behavioural span model pushed into a scoreboard queue;
// a negedge monitor pops and compares on every accepted beat.
module tb_gfx_span_rasterizer;

    localparam int unsigned PW = 16;
    localparam int unsigned LN = 4;

    typedef struct {
        int x; int y; int u; int v;
        logic [LN-1:0] m;
    } beat_t;

    typedef struct {
        int p0x; int p0y; int p1x; int p1y;
        bit ce;
        int cx0; int cy0; int cx1; int cy1;
        int sx; int sy;
    } cmd_t;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic cmd_valid_i = 1'b0;
    logic cmd_ready_o;
    logic signed [PW-1:0] p0_x_i = '0, p0_y_i = '0, p1_x_i = '0, p1_y_i = '0;
    logic clip_en_i = 1'b0;
    logic [PW-1:0] clip_x0_i = '0, clip_y0_i = '0, clip_x1_i = '0, clip_y1_i = '0;
    logic [PW-1:0] src_x_i = '0, src_y_i = '0;
    logic abort_i = 1'b0;
    logic pix_valid_o;
    logic pix_ready_i = 1'b1;
    logic [PW-1:0] x_o, y_o, u_o, v_o;
    logic [LN-1:0] mask_o;
    logic done_o, busy_o;

    gfx_span_rasterizer #(.POINT_WIDTH(PW), .LANES(LN), .TEX_EN(1)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .p0_x_i(p0_x_i), .p0_y_i(p0_y_i), .p1_x_i(p1_x_i), .p1_y_i(p1_y_i),
        .clip_en_i(clip_en_i),
        .clip_x0_i(clip_x0_i), .clip_y0_i(clip_y0_i), .clip_x1_i(clip_x1_i), .clip_y1_i(clip_y1_i),
        .src_x_i(src_x_i), .src_y_i(src_y_i),
        .abort_i(abort_i),
        .pix_valid_o(pix_valid_o), .pix_ready_i(pix_ready_i),
        .x_o(x_o), .y_o(y_o), .u_o(u_o), .v_o(v_o),
        .mask_o(mask_o), .done_o(done_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    beat_t sb_q[$];
    beat_t mon_e;
    int tests_run = 0;
    int tests_failed = 0;
    int hs_cnt = 0, done_cnt = 0, cyc = 0, last_hs_cyc = 0, done_cyc = 0;
    logic tog_mode = 1'b0;
    logic stall_prev = 1'b0;
    logic [PW-1:0] snap_x, snap_y, snap_u, snap_v;
    logic [LN-1:0] snap_m;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, want %0d", tag, act, exp);
        end
    endtask

    // Behavioural span model: clipped bounds, then LANES-wide beats per row.
    task automatic model_push(input cmd_t c, output int n);
        int c0x, c0y, c1x, c1y, xs, xe, ys, ye;
        beat_t b;
        c0x = c.ce ? c.cx0 : 0;
        c0y = c.ce ? c.cy0 : 0;
        c1x = c.ce ? c.cx1 : 32767;
        c1y = c.ce ? c.cy1 : 32767;
        xs = (c.p0x > c0x) ? c.p0x : c0x;
        ys = (c.p0y > c0y) ? c.p0y : c0y;
        xe = (c.p1x < c1x) ? c.p1x : c1x;
        ye = (c.p1y < c1y) ? c.p1y : c1y;
        n = 0;
        if (xs < xe && ys < ye) begin
            for (int y = ys; y < ye; y++) begin
                for (int x = xs; x < xe; x += int'(LN)) begin
                    b.x = x;
                    b.y = y;
                    b.u = (c.sx + x - c.p0x) & 32'h0000_FFFF;
                    b.v = (c.sy + y - c.p0y) & 32'h0000_FFFF;
                    for (int i = 0; i < int'(LN); i++) b.m[i] = (x + i < xe);
                    sb_q.push_back(b);
                    n++;
                end
            end
        end
    endtask

    // Ready is held high, or toggled every cycle in toggle mode.
    always @(posedge clk_i) begin
        #1;
        pix_ready_i = tog_mode ? ~pix_ready_i : 1'b1;
    end

    // Monitor: scoreboard pop on accepted beats, stall stability, done bookkeeping.
    always @(negedge clk_i) begin
        cyc++;
        if (rst_ni) begin
            if (stall_prev && pix_valid_o) begin
                check_eq("stall_x", 32'(x_o), 32'(snap_x));
                check_eq("stall_y", 32'(y_o), 32'(snap_y));
                check_eq("stall_u", 32'(u_o), 32'(snap_u));
                check_eq("stall_mask", 32'(mask_o), 32'(snap_m));
            end
            if (pix_valid_o && pix_ready_i && !abort_i) begin
                hs_cnt++;
                last_hs_cyc = cyc;
                if (sb_q.size() == 0) begin
                    check_eq("sb_depth", 32'(sb_q.size()), 1);
                end else begin
                    mon_e = sb_q.pop_front();
                    check_eq("beat_x", 32'(x_o), 32'(mon_e.x));
                    check_eq("beat_y", 32'(y_o), 32'(mon_e.y));
                    check_eq("beat_u", 32'(u_o), 32'(mon_e.u));
                    check_eq("beat_v", 32'(v_o), 32'(mon_e.v));
                    check_eq("beat_mask", 32'(mask_o), 32'(mon_e.m));
                end
            end
            stall_prev = pix_valid_o && !pix_ready_i && !abort_i;
            snap_x = x_o; snap_y = y_o; snap_u = u_o; snap_v = v_o; snap_m = mask_o;
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic issue(input cmd_t c);
        int n;
        n = 0;
        while (!cmd_ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        check_eq("cmd_ready_wait", 32'(cmd_ready_o), 1);
        p0_x_i = PW'(c.p0x); p0_y_i = PW'(c.p0y);
        p1_x_i = PW'(c.p1x); p1_y_i = PW'(c.p1y);
        clip_en_i = c.ce;
        clip_x0_i = PW'(c.cx0); clip_y0_i = PW'(c.cy0);
        clip_x1_i = PW'(c.cx1); clip_y1_i = PW'(c.cy1);
        src_x_i = PW'(c.sx); src_y_i = PW'(c.sy);
        cmd_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        cmd_valid_i = 1'b0;
    endtask

    // Issue one command and follow it to done_o, checking latency and beat count.
    task automatic run_cmd(input cmd_t c);
        int nexp, n, first_v, hs0;
        model_push(c, nexp);
        hs0 = hs_cnt;
        issue(c);
        n = 0;
        first_v = 0;
        while (n < 400) begin
            @(negedge clk_i);
            n++;
            if (n == 1) begin
                check_eq("setup_valid", 32'(pix_valid_o), 0);
                check_eq("setup_busy", 32'(busy_o), 1);
                check_eq("busy_cmd_ready", 32'(cmd_ready_o), 0);
            end
            if (pix_valid_o && first_v == 0) first_v = n;
            if (done_o) break;
        end
        #1;
        check_eq("done_seen", 32'(done_o), 1);
        if (nexp == 0) begin
            check_eq("empty_done_lat", 32'(n), 2);
            check_eq("empty_no_beat", 32'(first_v), 0);
        end else begin
            check_eq("first_beat_lat", 32'(first_v), 2);
            check_eq("done_after_last", 32'(done_cyc - last_hs_cyc), 1);
        end
        check_eq("beat_count", 32'(hs_cnt - hs0), 32'(nexp));
        check_eq("sb_drain", 32'(sb_q.size()), 0);
        @(negedge clk_i);
        check_eq("done_pulse_1cyc", 32'(done_o), 0);
        check_eq("ready_after_done", 32'(cmd_ready_o), 1);
        check_eq("idle_busy", 32'(busy_o), 0);
    endtask

    initial begin
        cmd_t c;
        int nexp, hs0, d0;

        // Reset state
        repeat (2) @(negedge clk_i);
        check_eq("rst_valid", 32'(pix_valid_o), 0);
        check_eq("rst_done", 32'(done_o), 0);
        check_eq("rst_busy", 32'(busy_o), 0);
        check_eq("rst_mask", 32'(mask_o), 0);
        check_eq("rst_xy", 32'({x_o, y_o}), 0);
        check_eq("rst_uv", 32'({u_o, v_o}), 0);
        check_eq("rst_ready", 32'(cmd_ready_o), 0);
        rst_ni = 1'b1;
        #1;
        check_eq("rel_ready_low", 32'(cmd_ready_o), 0);
        @(negedge clk_i);
        check_eq("rel_ready_rise", 32'(cmd_ready_o), 1);

        // Abort while idle does nothing
        abort_i = 1'b1;
        @(negedge clk_i);
        check_eq("idle_abort_ready", 32'(cmd_ready_o), 1);
        check_eq("idle_abort_busy", 32'(busy_o), 0);
        check_eq("idle_abort_done", 32'(done_o), 0);
        abort_i = 1'b0;

        // Basic 7x2 span, clip off
        c = '{2, 3, 9, 5, 1'b0, 0, 0, 0, 0, 0, 0};
        run_cmd(c);

        // Same span with ready toggling
        tog_mode = 1'b1;
        run_cmd(c);
        tog_mode = 1'b0;

        // Negative origin clipped to (0,0)-(100,100)
        run_cmd('{-5, -5, 3, 2, 1'b1, 0, 0, 100, 100, 10, 20});
        // Zero width
        run_cmd('{5, 5, 5, 9, 1'b0, 0, 0, 0, 0, 0, 0});
        // Clip cuts both sides
        run_cmd('{0, 0, 20, 3, 1'b1, 3, 1, 12, 10, 100, 200});
        // Entirely negative rectangle clipped away
        run_cmd('{-10, -10, -2, 5, 1'b0, 0, 0, 0, 0, 0, 0});
        // Width an exact multiple of LANES
        run_cmd('{0, 0, 8, 1, 1'b0, 0, 0, 0, 0, 7, 9});

        // Abort on the second beat
        model_push(c, nexp);
        hs0 = hs_cnt;
        issue(c);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        check_eq("abort_beat_x", 32'(x_o), 6);
        abort_i = 1'b1;
        @(posedge clk_i); #1;
        abort_i = 1'b0;
        @(negedge clk_i);
        check_eq("abort_valid", 32'(pix_valid_o), 0);
        check_eq("abort_done", 32'(done_o), 1);
        @(negedge clk_i);
        check_eq("abort_ready", 32'(cmd_ready_o), 1);
        check_eq("abort_done_low", 32'(done_o), 0);
        check_eq("abort_beats", 32'(hs_cnt - hs0), 1);
        check_eq("abort_left", 32'(sb_q.size()), 32'(nexp - 1));
        sb_q.delete();

        // Reset in the middle of EMIT
        model_push(c, nexp);
        d0 = done_cnt;
        issue(c);
        @(posedge clk_i); #1;
        @(posedge clk_i); #2;
        rst_ni = 1'b0;
        #1;
        check_eq("mid_rst_valid", 32'(pix_valid_o), 0);
        check_eq("mid_rst_busy", 32'(busy_o), 0);
        check_eq("mid_rst_x", 32'(x_o), 0);
        check_eq("mid_rst_mask", 32'(mask_o), 0);
        check_eq("mid_rst_ready", 32'(cmd_ready_o), 0);
        @(negedge clk_i);
        @(negedge clk_i);
        #1;
        rst_ni = 1'b1;
        sb_q.delete();
        @(negedge clk_i);
        check_eq("mid_rst_ready_rise", 32'(cmd_ready_o), 1);
        check_eq("mid_rst_no_done", 32'(done_cnt - d0), 0);
        run_cmd('{-5, -5, 3, 2, 1'b1, 0, 0, 100, 100, 10, 20});

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        tests_failed++;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
